// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - double-buffered RGB332 frame buffer scan-out with vblank bank swap
module fb_scanout #(
    parameter int HBITS = 8,
    parameter int VBITS = 8,
    parameter int DROPW = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_pix,
    input  logic [8:0]             hcount,
    input  logic [8:0]             vcount,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   hb_in,
    input  logic                   vb_in,
    input  logic                   frame_done,
    output logic                   wr_bank,
    output logic [HBITS+VBITS:0]   rd_addr,
    input  logic [7:0]             rd_data,
    output logic [7:0]             r,
    output logic [7:0]             g,
    output logic [7:0]             b,
    output logic                   hs,
    output logic                   vs,
    output logic                   hb,
    output logic                   vb,
    output logic                   de,
    output logic                   swap_pending,
    output logic [DROPW-1:0]       drop_cnt
);

    logic       disp_bank;
    logic       vb_prev;
    logic       vb_rise;
    logic       do_swap;
    logic       in_window;
    logic       win0;
    logic       hs0;
    logic       vs0;
    logic       hb0;
    logic       vb0;
    logic       ce_d;
    logic [7:0] pix_q;
    logic       active;
    logic [7:0] r_exp;
    logic [7:0] g_exp;
    logic [7:0] b_exp;

    assign wr_bank = ~disp_bank;

    // A swap is only legal on the vblank rising edge; a frame_done in that same clk still counts.
    assign vb_rise = ce_pix & vb_in & ~vb_prev;
    assign do_swap = vb_rise & (swap_pending | frame_done);

    // Counters past the framebuffer size still issue reads but the pixel is forced black.
    assign in_window = (int'(hcount) < (1 << HBITS)) && (int'(vcount) < (1 << VBITS));

    // Bank ownership, pending-frame flag and dropped-frame accounting.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
            drop_cnt     <= '0;
            vb_prev      <= 1'b0;
        end else begin
            if (do_swap) begin
                disp_bank    <= ~disp_bank;
                swap_pending <= 1'b0;
            end else if (frame_done) begin
                if (swap_pending) begin
                    if (drop_cnt != {DROPW{1'b1}}) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end else begin
                    swap_pending <= 1'b1;
                end
            end
            if (ce_pix) begin
                vb_prev <= vb_in;
            end
        end
    end

    // Address stage: issue the RAM read and hold timing alongside it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr <= '0;
            win0    <= 1'b0;
            hs0     <= 1'b0;
            vs0     <= 1'b0;
            hb0     <= 1'b0;
            vb0     <= 1'b0;
        end else if (ce_pix) begin
            rd_addr <= {disp_bank, vcount[VBITS-1:0], hcount[HBITS-1:0]};
            win0    <= in_window;
            hs0     <= hs_in;
            vs0     <= vs_in;
            hb0     <= hb_in;
            vb0     <= vb_in;
        end
    end

    // Capture RAM data one clk after the address was issued.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_d  <= 1'b0;
            pix_q <= '0;
        end else begin
            ce_d <= ce_pix;
            if (ce_d) begin
                pix_q <= rd_data;
            end
        end
    end

    // RGB332 to 8-bit-per-channel by bit replication, blanked outside the visible window.
    always_comb begin
        active = win0 & ~hb0 & ~vb0;
        r_exp  = 8'h00;
        g_exp  = 8'h00;
        b_exp  = 8'h00;
        if (active) begin
            r_exp = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
            g_exp = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
            b_exp = {pix_q[1:0], pix_q[1:0], pix_q[1:0], pix_q[1:0]};
        end
    end

    // Output stage: colour and delayed timing leave together.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b0;
            vs <= 1'b0;
            hb <= 1'b0;
            vb <= 1'b0;
            de <= 1'b0;
        end else if (ce_pix) begin
            r  <= r_exp;
            g  <= g_exp;
            b  <= b_exp;
            hs <= hs0;
            vs <= vs0;
            hb <= hb0;
            vb <= vb0;
            de <= ~(hb0 | vb0);
        end
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read side of the double-buffered 8bpp (RGB332) frame buffer.
- Owns bank selection: tells the pixel writer which bank to fill, and swaps banks only during vertical blank after the writer signals frame completion.
- Generates read addresses from the video timing counters, realigns sync and blank to the RAM read latency, and expands RGB332 to 8-bit-per-channel output.
- Sits between the video timing generator, the framebuffer RAM read port and the VGA_* outputs.

Parameters:
- HBITS, 8, log2 of framebuffer width in pixels (256).
- VBITS, 8, log2 of framebuffer height in lines (256).
- DROPW, 8, width of the dropped-frame counter.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel clock enable. Minimum spacing 2 clk_sys cycles.
- hcount  in  9  horizontal pixel counter from the timing generator.
- vcount  in  9  vertical line counter from the timing generator.
- hs_in, vs_in, hb_in, vb_in  in  1 each  raw timing signals, aligned with hcount/vcount.
- frame_done  in  1  one-clk pulse from the writer: the write bank holds a complete frame.
- wr_bank  out  1  bank the writer must target. Always ~disp_bank.
- rd_addr  out  HBITS+VBITS+1  RAM read address {disp_bank, vcount[VBITS-1:0], hcount[HBITS-1:0]}.
- rd_data  in  8  RAM read data {r[2:0], g[2:0], b[1:0]}, valid 1 clk_sys after rd_addr.
- r, g, b  out  8 each  expanded pixel colour.
- hs, vs, hb, vb  out  1 each  timing signals delayed to match r/g/b.
- de  out  1  ~(hb|vb) after delay.
- swap_pending  out  1  a completed frame is waiting for vblank.
- drop_cnt  out  DROPW  saturating count of frames overwritten before display.

Behaviour:
- Reset (async, reset_n=0): disp_bank=0, so wr_bank=1. swap_pending=0, drop_cnt=0, rd_addr=0, r/g/b=0, hs/vs/hb/vb=0, de=0, all pipeline registers 0.
- All state advances only on clk_sys edges with ce_pix=1, except the frame_done capture and the RAM data capture.
- frame_done capture, every clk_sys:
  - frame_done=1 and swap_pending=0: set swap_pending.
  - frame_done=1 and swap_pending=1: drop_cnt += 1, saturating at all-ones. swap_pending stays 1.
- Swap: the vblank rising edge is detected on a ce_pix cycle (vb_in=1, previous sampled vb_in=0).
  - On that cycle, if swap_pending=1 (or frame_done=1 in the same clk): toggle disp_bank and clear swap_pending. No drop is counted.
  - No swap at any other time. wr_bank changes in the same cycle as disp_bank.
- Address stage S0, on ce_pix:
  - rd_addr <= {disp_bank, vcount[7:0], hcount[7:0]}.
  - win0 <= (hcount < 2^HBITS) && (vcount < 2^VBITS).
  - Latch hs_in/vs_in/hb_in/vb_in into stage-0 delay registers.
- Data capture: 1 clk_sys after each ce_pix, capture rd_data into pix_q.
- Output stage S1, on the next ce_pix:
  - If win0 && !hb0 && !vb0: r={p[7:5],p[7:5],p[7:6]}, g={p[4:2],p[4:2],p[4:3]}, b={p[1:0],p[1:0],p[1:0],p[1:0]}. Otherwise r/g/b=0.
  - hs/vs/hb/vb <= stage-0 values. de <= ~(hb0|vb0).
- Latency: inputs to r/g/b/hs/vs/hb/vb/de is exactly 2 ce_pix periods; sync and colour stay aligned.
- Counter wrap: hcount/vcount ≥256 reads are still issued but forced black via win0.
- Reset mid-frame: the pipeline clears at once, bank returns to 0, and a pending swap is lost.

Test Plan:
- Reset release, hcount=5, vcount=3, disp_bank=0, two ce_pix with rd_data=8'hE0 -> rd_addr=17'h00305, r=8'hFF, g=0, b=0, wr_bank=1.
- rd_data=8'b010_101_10 in the active window -> r=8'h49, g=8'hB6, b=8'hAA on the second ce_pix; hs/vs match the inputs from 2 ce_pix earlier.
- frame_done pulse at line 100, vb_in rises at line 240 -> swap_pending=1 from line 100; at the vb edge disp_bank=1, wr_bank=0, swap_pending=0; next frame rd_addr[16]=1.
- Three frame_done pulses before one vblank edge -> drop_cnt=2, exactly one swap. 300 extra pulses with no vblank -> drop_cnt saturates at 8'hFF.
- frame_done in the same clk as the ce_pix vblank rising edge -> swap occurs, swap_pending=0, drop_cnt unchanged.
- hcount=260 with rd_data=8'hFF -> r/g/b=0. Assert reset_n=0 mid-line -> all outputs 0 immediately, disp_bank=0.
